// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - Tomasulo execution stage: adder and mul/div units sharing one CDB
// Optional restoring divider built when EXEC_DIV_EN is defined.
module exec_unit #(
    parameter int DW   = 16,
    parameter int ROBW = 3,
    parameter int RDW  = 4
) (
    input  logic            clk1,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      rs_index,
    input  logic [DW-1:0]   rs1_data,
    input  logic [DW-1:0]   rs2_data,
    input  logic [3:0]      func,
    input  logic [ROBW-1:0] rob_ind,
    input  logic [RDW-1:0]  rd,
    output logic            add_busy,
    output logic            mul_busy,
    output logic            issue_drop,
    output logic            cdb_valid,
    output logic [DW-1:0]   cdb_data,
    output logic [ROBW-1:0] cdb_rob,
    output logic [RDW-1:0]  cdb_rd,
    output logic [1:0]      cdb_rs_index,
    output logic            cdb_unit,
    output logic            cdb_err
);
    localparam int CW = $clog2(DW + 1);

    logic            add_sub;
    logic [DW-1:0]   add_a, add_b;
    logic [ROBW-1:0] add_rob;
    logic [RDW-1:0]  add_rd;
    logic [1:0]      add_rs;

    logic            mul_is_div;
    logic [DW-1:0]   mul_a, mul_b;
    logic [ROBW-1:0] mul_rob;
    logic [RDW-1:0]  mul_rd;
    logic [1:0]      mul_rs;
    logic [CW-1:0]   mul_cnt;

    logic            legal, accept_add, accept_mul;
    logic [CW-1:0]   mul_last;
    logic            mul_done, add_done;
    logic [DW-1:0]   add_result, mul_result;
    logic            mul_err;

`ifdef EXEC_DIV_EN
    logic [DW-1:0]   div_rem, div_quo;
    logic [DW:0]     rem_sh;
    logic [DW-1:0]   rem_sub;
    logic            rem_ge, div_step;
`endif

    always_comb begin
        legal      = (func[3:2] == 2'b00);
        accept_add = start && legal && !func[1] && !add_busy;
        accept_mul = start && legal &&  func[1] && !mul_busy;
        add_result = add_sub ? (add_a - add_b) : (add_a + add_b);
    end

    // mul_cnt counts edges since accept; the unit completes when it reaches mul_last
`ifdef EXEC_DIV_EN
    always_comb begin
        mul_last   = mul_is_div ? CW'(DW) : CW'(2);
        rem_sh     = {div_rem, div_quo[DW-1]};
        rem_ge     = (rem_sh >= {1'b0, mul_b});
        rem_sub    = rem_sh[DW-1:0] - mul_b;
        div_step   = mul_busy && mul_is_div && (mul_cnt < CW'(DW));
        mul_result = mul_is_div ? div_quo : mul_a * mul_b;
        mul_err    = mul_is_div && (mul_b == '0);
    end
`else
    always_comb begin
        mul_last   = CW'(2);
        mul_result = mul_is_div ? '0 : mul_a * mul_b;
        mul_err    = mul_is_div;
    end
`endif

    // mul/div wins the bus on a tie; the adder simply waits with busy still high
    always_comb begin
        mul_done = mul_busy && (mul_cnt == mul_last);
        add_done = add_busy && !mul_done;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            add_busy     <= 1'b0;
            mul_busy     <= 1'b0;
            issue_drop   <= 1'b0;
            cdb_valid    <= 1'b0;
            cdb_data     <= '0;
            cdb_rob      <= '0;
            cdb_rd       <= '0;
            cdb_rs_index <= '0;
            cdb_unit     <= 1'b0;
            cdb_err      <= 1'b0;
            add_sub      <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            add_rob      <= '0;
            add_rd       <= '0;
            add_rs       <= '0;
            mul_is_div   <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_rob      <= '0;
            mul_rd       <= '0;
            mul_rs       <= '0;
            mul_cnt      <= '0;
`ifdef EXEC_DIV_EN
            div_rem      <= '0;
            div_quo      <= '0;
`endif
        end else begin
            issue_drop   <= start && !(accept_add || accept_mul);
            cdb_valid    <= 1'b0;
            cdb_data     <= '0;
            cdb_rob      <= '0;
            cdb_rd       <= '0;
            cdb_rs_index <= '0;
            cdb_unit     <= 1'b0;
            cdb_err      <= 1'b0;

            if (mul_done) begin
                cdb_valid    <= 1'b1;
                cdb_data     <= mul_result;
                cdb_rob      <= mul_rob;
                cdb_rd       <= mul_rd;
                cdb_rs_index <= mul_rs;
                cdb_unit     <= 1'b1;
                cdb_err      <= mul_err;
                mul_busy     <= 1'b0;
            end else if (add_done) begin
                cdb_valid    <= 1'b1;
                cdb_data     <= add_result;
                cdb_rob      <= add_rob;
                cdb_rd       <= add_rd;
                cdb_rs_index <= add_rs;
                add_busy     <= 1'b0;
            end

            if (accept_add) begin
                add_busy <= 1'b1;
                add_sub  <= func[0];
                add_a    <= rs1_data;
                add_b    <= rs2_data;
                add_rob  <= rob_ind;
                add_rd   <= rd;
                add_rs   <= rs_index;
            end

            if (mul_busy && !mul_done)
                mul_cnt <= mul_cnt + CW'(1);

`ifdef EXEC_DIV_EN
            if (div_step) begin
                div_rem <= rem_ge ? rem_sub : rem_sh[DW-1:0];
                div_quo <= {div_quo[DW-2:0], rem_ge};
            end
`endif

            if (accept_mul) begin
                mul_busy   <= 1'b1;
                mul_is_div <= func[0];
                mul_a      <= rs1_data;
                mul_b      <= rs2_data;
                mul_rob    <= rob_ind;
                mul_rd     <= rd;
                mul_rs     <= rs_index;
                mul_cnt    <= '0;
`ifdef EXEC_DIV_EN
                div_rem    <= '0;
                div_quo    <= rs1_data;
`endif
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - table, random and corner-sequence bench for exec_unit
module tb_exec_unit;
    localparam int DW = 16, ROBW = 3, RDW = 4;
`ifdef EXEC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk1 = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]      rs_index = '0;
    logic [DW-1:0]   rs1_data = '0, rs2_data = '0;
    logic [3:0]      func = '0;
    logic [ROBW-1:0] rob_ind = '0;
    logic [RDW-1:0]  rd = '0;
    logic            add_busy, mul_busy, issue_drop, cdb_valid, cdb_unit, cdb_err;
    logic [DW-1:0]   cdb_data;
    logic [ROBW-1:0] cdb_rob;
    logic [RDW-1:0]  cdb_rd;
    logic [1:0]      cdb_rs_index;

    always #5 clk1 = ~clk1;

    exec_unit #(.DW(DW), .ROBW(ROBW), .RDW(RDW)) dut (
        .clk1(clk1), .rst(rst), .start(start), .rs_index(rs_index),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func),
        .rob_ind(rob_ind), .rd(rd), .add_busy(add_busy), .mul_busy(mul_busy),
        .issue_drop(issue_drop), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
        .cdb_rob(cdb_rob), .cdb_rd(cdb_rd), .cdb_rs_index(cdb_rs_index),
        .cdb_unit(cdb_unit), .cdb_err(cdb_err)
    );

    typedef struct {
        logic [3:0]  func;
        logic [15:0] a, b;
        logic [2:0]  rob;
        logic [3:0]  rd;
        logic [1:0]  rs;
        logic [15:0] exp_data;
        logic        exp_err;
        logic        exp_unit;
        int          exp_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] rob, input logic [3:0] rdi, input logic [1:0] rs);
        start = s; func = f; rs1_data = a; rs2_data = b; rob_ind = rob; rd = rdi; rs_index = rs;
    endtask

    function automatic logic [30:0] all_outs();
        return {add_busy, mul_busy, issue_drop, cdb_valid, cdb_data, cdb_rob, cdb_rd,
                cdb_rs_index, cdb_unit, cdb_err};
    endfunction

    function automatic logic [26:0] cdb_pack();
        return {cdb_data, cdb_rob, cdb_rd, cdb_rs_index, cdb_unit, cdb_err};
    endfunction

    // Reference model: plain integer arithmetic on the architectural rules
    function automatic vec_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] rob, input logic [3:0] rdi, input logic [1:0] rs);
        vec_t v;
        longint r;
        v.func = f; v.a = a; v.b = b; v.rob = rob; v.rd = rdi; v.rs = rs;
        v.exp_err = 1'b0;
        v.exp_unit = f[1];
        r = 0;
        case (f)
            4'd0: begin r = (longint'(a) + longint'(b)) % 65536; v.exp_lat = 1; end
            4'd1: begin r = (longint'(a) - longint'(b) + 65536) % 65536; v.exp_lat = 1; end
            4'd2: begin r = (longint'(a) * longint'(b)) % 65536; v.exp_lat = 3; end
            default: begin
                if (!DIV_EN) begin r = 0; v.exp_err = 1'b1; v.exp_lat = 3; end
                else if (b == 0) begin r = 65535; v.exp_err = 1'b1; v.exp_lat = 17; end
                else begin r = longint'(a) / longint'(b); v.exp_lat = 17; end
            end
        endcase
        v.exp_data = r[15:0];
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        drive(1'b1, v.func, v.a, v.b, v.rob, v.rd, v.rs);
        tick();
        start = 1'b0;
        chk({tag, " busy_rise"}, v.exp_unit ? mul_busy : add_busy, 1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (cdb_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " cdb"}, cdb_pack(), {v.exp_data, v.rob, v.rd, v.rs, v.exp_unit, v.exp_err});
        chk({tag, " busy_fall"}, {add_busy, mul_busy}, 0);
        tick();
        chk({tag, " idle_zero"}, {cdb_valid, cdb_pack()}, 0);
    endtask

    vec_t vecs[8];
    int   nvalid;

    initial begin
        vecs[0] = '{4'd0, 16'h0005, 16'h0003, 3'd2, 4'd7, 2'd1, 16'h0008, 1'b0, 1'b0, 1};
        vecs[1] = '{4'd1, 16'h0000, 16'h0001, 3'd3, 4'd1, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1};
        vecs[2] = '{4'd2, 16'h0100, 16'h0300, 3'd4, 4'd9, 2'd0, 16'h0000, 1'b0, 1'b1, 3};
        vecs[3] = '{4'd2, 16'h0007, 16'h0006, 3'd5, 4'd2, 2'd1, 16'h002A, 1'b0, 1'b1, 3};
        vecs[4] = '{4'd3, 16'h0064, 16'h0007, 3'd6, 4'd3, 2'd2,
                    DIV_EN ? 16'h000E : 16'h0000, !DIV_EN, 1'b1, DIV_EN ? 17 : 3};
        vecs[5] = '{4'd3, 16'h1234, 16'h0000, 3'd7, 4'd4, 2'd0,
                    DIV_EN ? 16'hFFFF : 16'h0000, 1'b1, 1'b1, DIV_EN ? 17 : 3};
        vecs[6] = '{4'd0, 16'hFFFF, 16'h0002, 3'd1, 4'd15, 2'd2, 16'h0001, 1'b0, 1'b0, 1};
        vecs[7] = '{4'd2, 16'hFFFF, 16'hFFFF, 3'd0, 4'd5, 2'd1, 16'h0001, 1'b0, 1'b1, 3};

        tick();
        tick();
        chk("reset_outputs", 32'(all_outs()), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  f;
            logic [15:0] a, b;
            f = 4'($urandom_range(0, 3));
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            run_op(model(f, a, b, 3'($urandom), 4'($urandom), 2'($urandom_range(0, 2))),
                   $sformatf("rnd%0d", i));
        end

        // busy reject at the broadcast edge, then earliest legal re-issue
        drive(1'b1, 4'd0, 16'h0010, 16'h0001, 3'd1, 4'd1, 2'd0);
        tick();
        drive(1'b1, 4'd0, 16'h0100, 16'h0100, 3'd3, 4'd3, 2'd2);
        tick();
        chk("busy_reject_drop", {issue_drop, cdb_valid, cdb_data, cdb_rob}, {1'b1, 1'b1, 16'h0011, 3'd1});
        drive(1'b1, 4'd0, 16'h0020, 16'h0002, 3'd4, 4'd5, 2'd1);
        tick();
        start = 1'b0;
        chk("reissue_accept", {issue_drop, add_busy, cdb_valid}, 3'b010);
        tick();
        chk("reissue_result", {cdb_valid, cdb_data, cdb_rob, cdb_rd}, {1'b1, 16'h0022, 3'd4, 4'd5});
        nvalid = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            nvalid += int'(cdb_valid);
        end
        chk("no_extra_broadcast", nvalid, 0);

        // illegal function code
        drive(1'b1, 4'b0100, 16'h0001, 16'h0001, 3'd2, 4'd2, 2'd0);
        tick();
        start = 1'b0;
        chk("illegal_drop", {issue_drop, add_busy, mul_busy}, 3'b100);
        tick();
        chk("drop_clears", issue_drop, 0);
        nvalid = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            nvalid += int'(cdb_valid);
        end
        chk("illegal_no_broadcast", nvalid, 0);

        // collision: mul at N, add at N+2, both ready at N+3
        drive(1'b1, 4'd2, 16'h0007, 16'h0006, 3'd5, 4'd2, 2'd1);
        tick();
        start = 1'b0;
        tick();
        drive(1'b1, 4'd0, 16'h0005, 16'h0003, 3'd2, 4'd7, 2'd0);
        tick();
        start = 1'b0;
        chk("add_during_mul", {issue_drop, add_busy, mul_busy}, 3'b011);
        tick();
        chk("collision_mul_first", {cdb_valid, cdb_unit, cdb_data, add_busy, mul_busy},
            {1'b1, 1'b1, 16'h002A, 1'b1, 1'b0});
        tick();
        chk("collision_add_next", {cdb_valid, cdb_unit, cdb_data, cdb_rob, add_busy},
            {1'b1, 1'b0, 16'h0008, 3'd2, 1'b0});
        tick();
        chk("collision_done", {cdb_valid, cdb_pack()}, 0);

        // reset in the middle of a multiply
        drive(1'b1, 4'd2, 16'h0003, 16'h0003, 3'd6, 4'd6, 2'd2);
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("reset_mid_mul", 32'(all_outs()), 0);
        tick();
        rst = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            nvalid += int'(cdb_valid);
        end
        chk("reset_no_broadcast", nvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
